// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory stage of the single-cycle CPU.
// Turns a load/store request into one req/ack bus transaction and stalls
// the core until it completes. A load returns sign- or zero-extended data.
// Optional build macro: MEM_MISALIGN_TRAP_EN. When it is defined, misaligned
// half/word accesses skip the bus and pulse MisalignErr instead.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255   // REQ cycles without BusAck before abort (1..65535)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  MemRdCtrl,
    input  logic [1:0]  MemWrCtrl,
    input  logic        MemRW,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic        Stall,
    output logic [31:0] RdData,
    output logic        BusErr,
    output logic        MisalignErr,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusBe,
    output logic [31:0] BusWData,
    input  logic        BusAck,
    input  logic [31:0] BusRData
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_W  = 3'd3;
    localparam logic [2:0] LD_BU = 3'd4;
    localparam logic [2:0] LD_HU = 3'd5;

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        bus_err_q, bus_err_d;
    logic        misalign_err_q, misalign_err_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  ld_type_q, ld_type_d;
    logic [1:0]  a_q, a_d;

    logic        is_load, is_store, access;
    size_e       size;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] rd_shift;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [16:0] cnt_inc;
    logic        misaligned;

    // Decode the request: a load takes priority over a simultaneous store.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        is_load  = (MemRdCtrl >= 3'd1) && (MemRdCtrl <= 3'd5);
        is_store = MemRW && (MemWrCtrl != 2'd0);
        access   = is_load || is_store;
        size     = SZ_WORD;
        if (is_load) begin
            case (MemRdCtrl)
                LD_B, LD_BU: size = SZ_BYTE;
                LD_H, LD_HU: size = SZ_HALF;
                default:     size = SZ_WORD;
            endcase
        end else begin
            case (MemWrCtrl)
                2'd1:    size = SZ_BYTE;
                2'd2:    size = SZ_HALF;
                default: size = SZ_WORD;
            endcase
        end
    end

    // Byte enables, replicated store data and the alignment check.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = WrData;
        case (size)
            SZ_BYTE: begin
                be_calc    = 4'b0001 << Addr[1:0];
                wdata_calc = {4{WrData[7:0]}};
            end
            SZ_HALF: begin
                be_calc    = Addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{WrData[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = WrData;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = ((size == SZ_HALF) && Addr[0]) ||
                     ((size == SZ_WORD) && (Addr[1:0] != 2'b00));
`else
        misaligned = 1'b0;
`endif
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        rd_shift = BusRData >> {a_q, 3'b000};
        half_sel = a_q[1] ? BusRData[31:16] : BusRData[15:0];
        case (ld_type_q)
            LD_B:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            LD_BU:   load_ext = {24'd0, rd_shift[7:0]};
            LD_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_ext = {16'd0, half_sel};
            LD_W:    load_ext = BusRData;
            default: load_ext = 32'd0;
        endcase
    end

    // Next-state and next-output logic of the access FSM.
    always_comb begin
        state_d        = state_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        rd_data_d      = rd_data_q;
        bus_err_d      = 1'b0;
        misalign_err_d = 1'b0;
        cnt_d          = cnt_q;
        ld_type_d      = ld_type_q;
        a_d            = a_q;
        cnt_inc        = {1'b0, cnt_q} + 17'd1;
        Stall          = 1'b0;

        case (state_q)
            S_IDLE: begin
                Stall     = access;
                bus_req_d = 1'b0;
                if (access) begin
                    bus_we_d    = !is_load;
                    bus_addr_d  = {Addr[31:2], 2'b00};
                    bus_be_d    = be_calc;
                    bus_wdata_d = wdata_calc;
                    ld_type_d   = is_load ? MemRdCtrl : 3'd0;
                    a_d         = Addr[1:0];
                    cnt_d       = 16'd0;
                    if (misaligned) begin
                        rd_data_d      = 32'd0;
                        misalign_err_d = 1'b1;
                        state_d        = S_DONE;
                    end else begin
                        bus_req_d = 1'b1;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                Stall = 1'b1;
                cnt_d = cnt_inc[15:0];
                if (BusAck) begin
                    rd_data_d = load_ext;
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_inc == 17'(TIMEOUT_CYCLES)) begin
                    rd_data_d = 32'd0;
                    bus_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                // S_DONE: the core retires the instruction this cycle.
                bus_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q        <= S_IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= 32'd0;
            bus_be_q       <= 4'd0;
            bus_wdata_q    <= 32'd0;
            rd_data_q      <= 32'd0;
            bus_err_q      <= 1'b0;
            misalign_err_q <= 1'b0;
            cnt_q          <= 16'd0;
            ld_type_q      <= 3'd0;
            a_q            <= 2'd0;
        end else begin
            state_q        <= state_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            rd_data_q      <= rd_data_d;
            bus_err_q      <= bus_err_d;
            misalign_err_q <= misalign_err_d;
            cnt_q          <= cnt_d;
            ld_type_q      <= ld_type_d;
            a_q            <= a_d;
        end
    end

    assign BusReq   = bus_req_q;
    assign BusWe    = bus_we_q;
    assign BusAddr  = bus_addr_q;
    assign BusBe    = bus_be_q;
    assign BusWData = bus_wdata_q;
    assign RdData   = rd_data_q;
    assign BusErr   = bus_err_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign MisalignErr = misalign_err_q;
`else
    assign MisalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
// Table of load/store vectors driven by one task; expected results are pushed
// to a scoreboard at drive time and popped when the DUT reaches DONE.
// Hand sequences cover reset, no-access codes and the misalignment trap.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  MemRdCtrl;
    logic [1:0]  MemWrCtrl;
    logic        MemRW;
    logic [31:0] Addr;
    logic [31:0] WrData;
    logic        Stall;
    logic [31:0] RdData;
    logic        BusErr;
    logic        MisalignErr;
    logic        BusReq;
    logic        BusWe;
    logic [31:0] BusAddr;
    logic [3:0]  BusBe;
    logic [31:0] BusWData;
    logic        BusAck;
    logic [31:0] BusRData;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRdCtrl(MemRdCtrl), .MemWrCtrl(MemWrCtrl), .MemRW(MemRW),
        .Addr(Addr), .WrData(WrData),
        .Stall(Stall), .RdData(RdData), .BusErr(BusErr), .MisalignErr(MisalignErr),
        .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusBe(BusBe),
        .BusWData(BusWData), .BusAck(BusAck), .BusRData(BusRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rd;
        logic [1:0]  wr;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // REQ cycles before ack; -1 = never ack
        logic [3:0]  exp_be;
        logic        exp_we;
        logic        chk_wd;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          stall;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRdCtrl = 3'd0;
        MemWrCtrl = 2'd0;
        MemRW     = 1'b0;
        Addr      = 32'd0;
        WrData    = 32'd0;
    endtask

    // Drive one vector starting just after a rising edge and follow it to DONE.
    task automatic run_vec(input vec_t v);
        exp_t   e;
        int     stall_n = 0;
        int     req_n   = 0;
        logic   done    = 1'b0;
        logic [31:0] exp_addr;
        exp_addr  = {v.addr[31:2], 2'b00};
        sb.push_back('{v.exp_rd, v.exp_err, v.exp_stall});
        MemRdCtrl = v.rd;
        MemWrCtrl = v.wr;
        MemRW     = v.rw;
        Addr      = v.addr;
        WrData    = v.wdata;
        BusRData  = v.rdata;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            BusAck = 1'b0;
            if (Stall) begin
                stall_n++;
                if (BusReq) begin
                    check("bus_addr", BusAddr, exp_addr);
                    check("bus_be", {28'd0, BusBe}, {28'd0, v.exp_be});
                    check("bus_we", {31'd0, BusWe}, {31'd0, v.exp_we});
                    if (v.chk_wd) check("bus_wdata", BusWData, v.exp_wd);
                    if (req_n == v.ack_dly) BusAck = 1'b1;
                    req_n++;
                end
            end else begin
                done = 1'b1;
                e = sb.pop_front();
                check("rd_data", RdData, e.rd);
                check("bus_err", {31'd0, BusErr}, {31'd0, e.err});
                check("stall_cycles", stall_n, e.stall);
                check("done_req_low", {31'd0, BusReq}, 32'd0);
                check("done_misalign", {31'd0, MisalignErr}, 32'd0);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no DONE expected DONE within 64 cycles");
        end
        @(posedge clk);
        #1;
        idle_inputs();
        BusAck = 1'b0;
    endtask

    initial begin
        // rd wr rw addr wdata rdata dly be we chk_wd exp_wd exp_rd err stall
        vecs.push_back('{3'd3, 2'd0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 0,  4'hF, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2});
        vecs.push_back('{3'd1, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80123456, 0,  4'h8, 1'b0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0, 2});
        vecs.push_back('{3'd4, 2'd0, 1'b0, 32'h103, 32'h0,        32'h80123456, 0,  4'h8, 1'b0, 1'b0, 32'h0,        32'h00000080, 1'b0, 2});
        vecs.push_back('{3'd0, 2'd2, 1'b1, 32'h202, 32'h1234ABCD, 32'h55555555, 2,  4'hC, 1'b1, 1'b1, 32'hABCDABCD, 32'h0,        1'b0, 4});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 32'h104, 32'h0,        32'h99999999, -1, 4'hF, 1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 5});
        vecs.push_back('{3'd2, 2'd0, 1'b0, 32'h102, 32'h0,        32'h80011234, 1,  4'hC, 1'b0, 1'b0, 32'h0,        32'hFFFF8001, 1'b0, 3});
        vecs.push_back('{3'd5, 2'd0, 1'b0, 32'h100, 32'h0,        32'h1234F00D, 0,  4'h3, 1'b0, 1'b0, 32'h0,        32'h0000F00D, 1'b0, 2});
        vecs.push_back('{3'd0, 2'd1, 1'b1, 32'h101, 32'h000000A5, 32'h0,        1,  4'h2, 1'b1, 1'b1, 32'hA5A5A5A5, 32'h0,        1'b0, 3});
        vecs.push_back('{3'd0, 2'd3, 1'b1, 32'h300, 32'hCAFEF00D, 32'h0,        0,  4'hF, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 2});
        // load and store together: the load wins
        vecs.push_back('{3'd1, 2'd3, 1'b1, 32'h102, 32'hFFFFFFFF, 32'h007F0000, 0,  4'h4, 1'b0, 1'b0, 32'h0,        32'h0000007F, 1'b0, 2});
`ifndef MEM_MISALIGN_TRAP_EN
        // misaligned accesses fall back to the truncating lane rules
        vecs.push_back('{3'd2, 2'd0, 1'b0, 32'h101, 32'h0,        32'hAAAA8765, 0,  4'h3, 1'b0, 1'b0, 32'h0,        32'hFFFF8765, 1'b0, 2});
        vecs.push_back('{3'd3, 2'd0, 1'b0, 32'h103, 32'h0,        32'h01020304, 0,  4'hF, 1'b0, 1'b0, 32'h0,        32'h01020304, 1'b0, 2});
`endif

        idle_inputs();
        BusAck   = 1'b0;
        BusRData = 32'd0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_req", {31'd0, BusReq}, 32'd0);
        check("rst_rd", RdData, 32'd0);
        check("rst_addr", BusAddr, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Codes 6/7 and a store without MemRW are not accesses.
        MemRdCtrl = 3'd6;
        MemWrCtrl = 2'd3;
        MemRW     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("noacc_stall", {31'd0, Stall}, 32'd0);
            check("noacc_req", {31'd0, BusReq}, 32'd0);
            MemRdCtrl = 3'd7;
        end
        @(posedge clk);
        #1;
        idle_inputs();

        // Reset in the middle of REQ, then a late ack.
        MemRdCtrl = 3'd3;
        Addr      = 32'h400;
        BusRData  = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        check("rreq_active", {31'd0, BusReq}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        BusAck = 1'b1;
        #1;
        check("rreq_req", {31'd0, BusReq}, 32'd0);
        check("rreq_stall", {31'd0, Stall}, 32'd0);
        check("rreq_rd", RdData, 32'd0);
        check("rreq_addr", BusAddr, 32'd0);
        check("rreq_be", {28'd0, BusBe}, 32'd0);
        check("rreq_wd", BusWData, 32'd0);
        @(negedge clk);
        BusAck = 1'b0;
        check("late_ack_req", {31'd0, BusReq}, 32'd0);
        check("late_ack_rd", RdData, 32'd0);
        check("late_ack_err", {31'd0, BusErr}, 32'd0);
        check("late_ack_stall", {31'd0, Stall}, 32'd0);

`ifdef MEM_MISALIGN_TRAP_EN
        // Misaligned half and word: no bus cycle, MisalignErr in the second cycle.
        for (int m = 0; m < 2; m++) begin
            @(posedge clk);
            #1;
            MemRdCtrl = (m == 0) ? 3'd2 : 3'd3;
            Addr      = (m == 0) ? 32'h101 : 32'h102;
            @(negedge clk);
            check("mis_stall1", {31'd0, Stall}, 32'd1);
            check("mis_req1", {31'd0, BusReq}, 32'd0);
            @(negedge clk);
            check("mis_stall2", {31'd0, Stall}, 32'd0);
            check("mis_err", {31'd0, MisalignErr}, 32'd1);
            check("mis_req2", {31'd0, BusReq}, 32'd0);
            check("mis_rd", RdData, 32'd0);
            @(posedge clk);
            #1;
            idle_inputs();
            @(negedge clk);
            check("mis_pulse_end", {31'd0, MisalignErr}, 32'd0);
        end
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_left: got %0d expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
